keypad_scanner: RTL and testbench

- Scans a 4x4 active-low matrix keypad, synchronises and debounces the column inputs, and decodes each confirmed key press into a single-cycle event.
- Sits directly upstream of the calculator control FSM and drives its num, OP, C and EQ inputs.
- Also supplies the pressed digit value and operator code to the save/operand datapath.

---
 rtl/keypad_scanner.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one row at a time, synchronises and
// debounces the column returns, and turns every confirmed key press into a
// single-cycle event for the calculator control FSM. The most recent digit
// value and operator code are held for the operand datapath.
//
// Parameters
//   SCAN_DIV          clock cycles per row slot (>= 4)
//   DEBOUNCE_SAMPLES  identical samples needed to confirm press/release (1..15)
//
// Ports
//   clk       system clock
//   resetn    asynchronous active-low reset
//   col_n     keypad column returns, active low, asynchronous to clk
//   row_n     keypad row drive, one-hot active low
//   num       1-cycle pulse: digit key 0-9 confirmed
//   OP        1-cycle pulse: operator key (A, B, D, *) confirmed
//   C         1-cycle pulse: clear key confirmed
//   EQ        1-cycle pulse: equals key (#) confirmed
//   digit     value of the last confirmed digit key
//   op_code   code of the last confirmed operator key
//                00 add (A), 01 sub (B), 10 mul (D), 11 div (*)
//   key_held  high while a confirmed key is still pressed
//
// Key map [row][col]:
//   row 0: 1 2 3 A      row 2: 7 8 9 C
//   row 1: 4 5 6 B      row 3: * 0 # D
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV         = 1000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       num,
  output logic       OP,
  output logic       C,
  output logic       EQ,
  output logic [3:0] digit,
  output logic [1:0] op_code,
  output logic       key_held
);

  localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_TARGET = 4'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  typedef enum logic [1:0] {
    K_DIGIT,
    K_OP,
    K_CLEAR,
    K_EQUALS
  } key_kind_t;

  typedef struct packed {
    key_kind_t  kind;
    logic [3:0] value;
    logic [1:0] op;
  } key_t;

  // Translate a matrix position into what the key means to the calculator.
  function automatic key_t decode_key(input logic [1:0] row, input logic [1:0] col);
    key_t k;
    k = '{kind: K_DIGIT, value: 4'd0, op: 2'b00};
    unique case ({row, col})
      4'h0: k.value = 4'd1;
      4'h1: k.value = 4'd2;
      4'h2: k.value = 4'd3;
      4'h3: begin k.kind = K_OP; k.op = 2'b00; end   // A: add
      4'h4: k.value = 4'd4;
      4'h5: k.value = 4'd5;
      4'h6: k.value = 4'd6;
      4'h7: begin k.kind = K_OP; k.op = 2'b01; end   // B: sub
      4'h8: k.value = 4'd7;
      4'h9: k.value = 4'd8;
      4'hA: k.value = 4'd9;
      4'hB: k.kind = K_CLEAR;                        // C
      4'hC: begin k.kind = K_OP; k.op = 2'b11; end   // *: div
      4'hD: k.value = 4'd0;
      4'hE: k.kind = K_EQUALS;                       // #
      4'hF: begin k.kind = K_OP; k.op = 2'b10; end   // D: mul
    endcase
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [3:0]       col_meta, col_sync;
  logic [DIV_W-1:0] div_q;
  state_t           state_q, state_d;
  logic [3:0]       row_n_d;
  logic [1:0]       cand_row_q, cand_row_d;
  logic [1:0]       cand_col_q, cand_col_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       rel_q, rel_d;
  logic             num_d, op_d, c_d, eq_d;
  logic [3:0]       digit_d;
  logic [1:0]       op_code_d;

  // ---------------------------------------------------------------------------
  // Column synchroniser and row-slot divider
  // ---------------------------------------------------------------------------
  // Synchroniser flops reset to the idle (all released) level so that reset
  // release never looks like a key.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
      div_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values and the two synchroniser stages stay distinct.
      col_meta <= col_n;
      col_sync <= col_meta;
      div_q    <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  logic tick;
  assign tick = (div_q == DIV_LAST);

  // ---------------------------------------------------------------------------
  // Sample classification
  // ---------------------------------------------------------------------------
  logic       single;
  logic       any_low;
  logic [1:0] sample_col;
  logic [1:0] cur_row;
  logic [3:0] row_next;

  always_comb begin
    single     = 1'b1;
    sample_col = 2'd0;
    unique case (col_sync)
      4'b1110: sample_col = 2'd0;
      4'b1101: sample_col = 2'd1;
      4'b1011: sample_col = 2'd2;
      4'b0111: sample_col = 2'd3;
      default: single     = 1'b0;  // none or several columns low
    endcase
  end

  assign any_low = (col_sync != 4'hF);

  // Row index of the row currently being driven.
  always_comb begin
    cur_row = 2'd0;
    unique case (row_n)
      4'b1110: cur_row = 2'd0;
      4'b1101: cur_row = 2'd1;
      4'b1011: cur_row = 2'd2;
      4'b0111: cur_row = 2'd3;
      default: cur_row = 2'd0;
    endcase
  end

  // Rotating the active-low pattern left walks rows 0 -> 1 -> 2 -> 3 -> 0.
  assign row_next = {row_n[2:0], row_n[3]};

  // ---------------------------------------------------------------------------
  // Scan / debounce / held FSM: next-state and event logic
  // ---------------------------------------------------------------------------
  always_comb begin
    key_t key;
    logic confirm;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    row_n_d    = row_n;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    count_d    = count_q;
    rel_d      = rel_q;
    num_d      = 1'b0;
    op_d       = 1'b0;
    c_d        = 1'b0;
    eq_d       = 1'b0;
    digit_d    = digit;
    op_code_d  = op_code;
    key        = '{kind: K_DIGIT, value: 4'd0, op: 2'b00};
    confirm    = 1'b0;

    if (tick) begin
      unique case (state_q)
        S_SCAN: begin
          if (single) begin
            // Freeze the row on the first clean sample and start counting.
            cand_row_d = cur_row;
            cand_col_d = sample_col;
            count_d    = 4'd1;
            if (DEB_TARGET == 4'd1) begin
              key     = decode_key(cur_row, sample_col);
              confirm = 1'b1;
              rel_d   = 4'd0;
              state_d = S_HELD;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end else begin
            row_n_d = row_next;
          end
        end

        S_DEBOUNCE: begin
          if (single && sample_col == cand_col_q && cur_row == cand_row_q) begin
            count_d = count_q + 4'd1;
            if (count_q + 4'd1 == DEB_TARGET) begin
              key     = decode_key(cand_row_q, cand_col_q);
              confirm = 1'b1;
              rel_d   = 4'd0;
              state_d = S_HELD;
            end
          end else begin
            // Any disagreement abandons the candidate without an event.
            count_d = 4'd0;
            row_n_d = row_next;
            state_d = S_SCAN;
          end
        end

        S_HELD: begin
          // Any low column on the frozen row, including a second key, keeps
          // the release count at zero; there is no auto-repeat.
          if (any_low) begin
            rel_d = 4'd0;
          end else if (rel_q + 4'd1 == DEB_TARGET) begin
            rel_d   = 4'd0;
            count_d = 4'd0;
            row_n_d = row_next;
            state_d = S_SCAN;
          end else begin
            rel_d = rel_q + 4'd1;
          end
        end

        default: begin
          state_d = S_SCAN;
          row_n_d = 4'b1110;
        end
      endcase
    end

    // Only one key is confirmed at a time, so at most one pulse is raised.
    if (confirm) begin
      unique case (key.kind)
        K_DIGIT: begin
          num_d   = 1'b1;
          digit_d = key.value;
        end
        K_OP: begin
          op_d      = 1'b1;
          op_code_d = key.op;
        end
        K_CLEAR:  c_d  = 1'b1;
        K_EQUALS: eq_d = 1'b1;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_SCAN;
      row_n      <= 4'b1110;
      cand_row_q <= 2'd0;
      cand_col_q <= 2'd0;
      count_q    <= 4'd0;
      rel_q      <= 4'd0;
      num        <= 1'b0;
      OP         <= 1'b0;
      C          <= 1'b0;
      EQ         <= 1'b0;
      digit      <= 4'd0;
      op_code    <= 2'b00;
    end else begin
      state_q    <= state_d;
      row_n      <= row_n_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      count_q    <= count_d;
      rel_q      <= rel_d;
      num        <= num_d;
      OP         <= op_d;
      C          <= c_d;
      EQ         <= eq_d;
      digit      <= digit_d;
      op_code    <= op_code_d;
    end
  end

  assign key_held = (state_q == S_HELD);

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SAMPLES=3.
// A model keypad turns the driven row and the set of pressed keys into col_n.
// Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       num, OP, C, EQ;
  logic [3:0] digit;
  logic [1:0] op_code;
  logic       key_held;

  // press[row*4 + col] = 1 while that key is physically down.
  logic [15:0] press;

  keypad_scanner #(
    .SCAN_DIV         (SCAN_DIV),
    .DEBOUNCE_SAMPLES (DEB)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .col_n    (col_n),
    .row_n    (row_n),
    .num      (num),
    .OP       (OP),
    .C        (C),
    .EQ       (EQ),
    .digit    (digit),
    .op_code  (op_code),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Model keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4 + c] && !row_n[r]) col_n[c] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Event monitor
  // ---------------------------------------------------------------------------
  int         num_cnt   = 0;
  int         op_cnt    = 0;
  int         c_cnt     = 0;
  int         eq_cnt    = 0;
  int         multi_cnt = 0;
  int         held_cyc  = 0;
  logic [3:0] last_digit = 4'hF;
  logic [1:0] op_first   = 2'b11;
  logic [1:0] op_second  = 2'b11;

  always @(negedge clk) begin
    if (num) begin
      num_cnt++;
      last_digit = digit;
    end
    if (OP) begin
      if (op_cnt == 0) op_first = op_code;
      else if (op_cnt == 1) op_second = op_code;
      op_cnt++;
    end
    if (C)  c_cnt++;
    if (EQ) eq_cnt++;
    if ((int'(num) + int'(OP) + int'(C) + int'(EQ)) > 1) multi_cnt++;
    if (key_held) held_cyc++;
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic wait_held(input logic lvl, input int budget, output int n);
    n = 0;
    while (key_held !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Press one key for 'hold' cycles, then release and wait for key_held to drop.
  task automatic key_tap(input int idx, input int hold, input string tag);
    int n;
    press[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    check({tag, "_held"}, key_held, 1'b1);
    press[idx] = 1'b0;
    wait_held(1'b0, 40, n);
    check({tag, "_released"}, key_held, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int         n;
    int         base_num, base_op, base_c, base_eq, base_held;
    logic [3:0] seen;

    resetn = 1'b0;
    press  = '0;
    press[5] = 1'b1;                       // key '5' held from before reset release
    repeat (3) @(negedge clk);

    check("rst_row_n",    row_n,    4'b1110);
    check("rst_num",      num,      1'b0);
    check("rst_op",       OP,       1'b0);
    check("rst_c",        C,        1'b0);
    check("rst_eq",       EQ,       1'b0);
    check("rst_digit",    digit,    4'd0);
    check("rst_op_code",  op_code,  2'b00);
    check("rst_key_held", key_held, 1'b0);

    // ---- 1: key '5' stable from reset release ------------------------------
    // Row 0 tick at cycle 4, row 1 from then; samples at 8, 12, 16; pulse
    // visible on the falling edge after cycle 16.
    resetn = 1'b1;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      n = i;
      if (num) break;
    end
    check("t1_latency",     n,     16);
    check("t1_digit_pulse", digit, 4'd5);

    repeat (20) @(negedge clk);
    check("t1_held_before_release", key_held, 1'b1);
    press[5] = 1'b0;
    wait_held(1'b0, 40, n);
    // 2 sync cycles, first tick 3..6 cycles after release, two more ticks.
    check("t1_release_window", (n >= 11 && n <= 14), 1'b1);
    repeat (40) @(negedge clk);
    #1;
    check("t1_num_count",  num_cnt,    1);
    check("t1_last_digit", last_digit, 4'd5);
    check("t1_other_pulses", op_cnt + c_cnt + eq_cnt, 0);

    // ---- 2: 'A' then 'B' ----------------------------------------------------
    key_tap(3, 40, "t2_A");
    key_tap(7, 40, "t2_B");
    repeat (8) @(negedge clk);
    #1;
    check("t2_op_count",  op_cnt,    2);
    check("t2_op_first",  op_first,  2'b00);
    check("t2_op_second", op_second, 2'b01);
    check("t2_digit_kept", digit,    4'd5);
    check("t2_num_count", num_cnt,   1);

    // ---- 3: bouncing '7' ----------------------------------------------------
    base_num  = num_cnt;
    base_held = held_cyc;
    for (int k = 0; k < 3; k++) begin
      press[8] = 1'b1;
      repeat (2*SCAN_DIV) @(negedge clk);
      press[8] = 1'b0;
      repeat (SCAN_DIV) @(negedge clk);
    end
    seen = 4'h0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | ~row_n;
    end
    #1;
    check("t3_no_num",      num_cnt,  base_num);
    check("t3_never_held",  held_cyc, base_held);
    check("t3_rows_rotate", seen,     4'hF);

    // ---- 4: 'C' then '#' ----------------------------------------------------
    base_num = num_cnt;
    base_op  = op_cnt;
    base_c   = c_cnt;
    base_eq  = eq_cnt;
    key_tap(11, 10*SCAN_DIV, "t4_C");
    #1;
    check("t4_c_count",     c_cnt,  base_c + 1);
    check("t4_eq_none_yet", eq_cnt, base_eq);
    key_tap(14, 10*SCAN_DIV, "t4_EQ");
    #1;
    check("t4_eq_count",  eq_cnt,  base_eq + 1);
    check("t4_c_single",  c_cnt,   base_c + 1);
    check("t4_num_quiet", num_cnt, base_num);
    check("t4_op_quiet",  op_cnt,  base_op);

    // ---- 5: '1' and '2' together --------------------------------------------
    base_held = held_cyc;
    press[0] = 1'b1;
    press[1] = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("t5_never_held", held_cyc, base_held);
    check("t5_no_pulses",  num_cnt + op_cnt + c_cnt + eq_cnt,
                           base_num + base_op + base_c + base_eq + 2);
    press[0] = 1'b0;
    press[1] = 1'b0;
    repeat (8) @(negedge clk);

    // ---- 6a: reset during DEBOUNCE of '9' ------------------------------------
    // Press while row 3 is driven so row 2 is entered cleanly afterwards.
    n = 0;
    while (row_n !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
    check("t6_reach_row3", row_n, 4'b0111);
    press[10] = 1'b1;
    n = 0;
    while (row_n !== 4'b1011 && n < 40) begin @(negedge clk); n++; end
    check("t6_reach_row2", row_n, 4'b1011);
    // Without a candidate the row would have moved after 4 cycles.
    repeat (5) @(negedge clk);
    check("t6_in_debounce", row_n, 4'b1011);
    base_num = num_cnt;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("t6a_row_n",    row_n,    4'b1110);
    check("t6a_num",      num,      1'b0);
    check("t6a_digit",    digit,    4'd0);
    check("t6a_op_code",  op_code,  2'b00);
    check("t6a_key_held", key_held, 1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    // Full rescan: row 2 reached after cycle 8, samples at 12, 16, 20.
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      n = i;
      if (num) break;
    end
    check("t6a_relatency", n,     20);
    check("t6a_digit9",    digit, 4'd9);
    #1;
    check("t6a_num_count", num_cnt, base_num + 1);
    repeat (10) @(negedge clk);
    press[10] = 1'b0;
    wait_held(1'b0, 40, n);
    check("t6a_released", key_held, 1'b0);

    // ---- 6b: reset during HELD of '0' ---------------------------------------
    press[13] = 1'b1;
    wait_held(1'b1, 60, n);
    check("t6b_held", key_held, 1'b1);
    repeat (5) @(negedge clk);
    check("t6b_digit0", digit, 4'd0);
    #1;
    check("t6b_last_digit", last_digit, 4'd0);
    base_num = num_cnt;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("t6b_row_n",    row_n,    4'b1110);
    check("t6b_key_held", key_held, 1'b0);
    check("t6b_num",      num,      1'b0);
    press[13] = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(negedge clk);
    #1;
    check("t6b_no_pulse_after", num_cnt,  base_num);
    check("t6b_idle",           key_held, 1'b0);

    check("one_pulse_per_cycle", multi_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
